// File: rtl/conv_mac_sequencer_if.sv
// Purpose : bundles the start/size control, x/h memory read ports and y memory write port of conv_mac_sequencer.
// Latency : none, wires only.
// Backpressure: none; memories are fixed one-cycle synchronous reads.
// Ports (slave = the sequencer, master = its environment):
//   start_i, size_x_i, size_h_i        run control and lengths N, M
//   x_addr_o/x_data_i, h_addr_o/h_data_i  sample memory read ports
//   y_we_o, y_addr_o, y_data_o         result memory write port
//   busy_o, done_o                     status
interface conv_mac_sequencer_if #(
    parameter int DATA_WIDTH   = 5,
    parameter int SAMPLE_WIDTH = 8,
    parameter int ACC_WIDTH    = 2*SAMPLE_WIDTH+DATA_WIDTH
);
    logic                    start_i;
    logic [DATA_WIDTH-1:0]   size_x_i;
    logic [DATA_WIDTH-1:0]   size_h_i;
    logic [DATA_WIDTH-1:0]   x_addr_o;
    logic [SAMPLE_WIDTH-1:0] x_data_i;
    logic [DATA_WIDTH-1:0]   h_addr_o;
    logic [SAMPLE_WIDTH-1:0] h_data_i;
    logic                    y_we_o;
    logic [DATA_WIDTH:0]     y_addr_o;
    logic [ACC_WIDTH-1:0]    y_data_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  start_i, size_x_i, size_h_i, x_data_i, h_data_i,
        output x_addr_o, h_addr_o, y_we_o, y_addr_o, y_data_o, busy_o, done_o
    );

    modport master (
        output start_i, size_x_i, size_h_i, x_data_i, h_data_i,
        input  x_addr_o, h_addr_o, y_we_o, y_addr_o, y_data_o, busy_o, done_o
    );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Purpose : 1-D convolution engine y[i] = sum_j x[j]*h[i-j]; walks i and j, reads x/h, accumulates, writes y[i].
// Latency : 1 (LOAD) + sum_i(2 + 2*taps_i) cycles after the accepted start, then a one-cycle done_o.
// Backpressure: none; start_i is ignored while busy_o is high and memories must return data one cycle after the address.
// Ports: clk, rstn (async active-low) plus the slave side of conv_mac_sequencer_if (see that file).
module conv_mac_sequencer #(
    parameter int DATA_WIDTH   = 5,
    parameter int SAMPLE_WIDTH = 8,
    parameter int ACC_WIDTH    = 2*SAMPLE_WIDTH+DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    conv_mac_sequencer_if.slave   bus
);

    localparam int IW = DATA_WIDTH + 1;   // i spans 0..N+M-2
    localparam int PW = 2 * SAMPLE_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_INIT_J = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_MAC    = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] n_q;
    logic [DATA_WIDTH-1:0] m_q;
    logic [IW-1:0]         i_q;
    logic [DATA_WIDTH-1:0] j_q;
    logic [DATA_WIDTH-1:0] j_end_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [DATA_WIDTH-1:0] x_addr_q;
    logic [DATA_WIDTH-1:0] h_addr_q;
    logic                  y_we_q;
    logic [IW-1:0]         y_addr_q;
    logic [ACC_WIDTH-1:0]  y_data_q;

    logic [IW-1:0]         n_ext;
    logic [IW-1:0]         m_ext;
    logic [IW-1:0]         i_last;
    logic [DATA_WIDTH-1:0] j_start_c;
    logic [DATA_WIDTH-1:0] j_end_c;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  acc_next;

    always_comb begin
        n_ext  = {1'b0, n_q};
        m_ext  = {1'b0, m_q};
        i_last = n_ext + m_ext - IW'(2);
        // j_start = max(0, i-(M-1)); written as i+1 >= M to stay unsigned.
        if (i_q + IW'(1) >= m_ext) begin
            j_start_c = DATA_WIDTH'(i_q + IW'(1) - m_ext);
        end else begin
            j_start_c = '0;
        end
        // j_end = min(i, N-1)
        if (i_q < n_ext - IW'(1)) begin
            j_end_c = DATA_WIDTH'(i_q);
        end else begin
            j_end_c = n_q - DATA_WIDTH'(1);
        end
        prod     = {{SAMPLE_WIDTH{1'b0}}, bus.x_data_i} * {{SAMPLE_WIDTH{1'b0}}, bus.h_data_i};
        acc_next = acc_q + {{(ACC_WIDTH-PW){1'b0}}, prod};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            j_end_q  <= '0;
            acc_q    <= '0;
            x_addr_q <= '0;
            h_addr_q <= '0;
            y_we_q   <= 1'b0;
            y_addr_q <= '0;
            y_data_q <= '0;
        end else begin
            y_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        n_q   <= bus.size_x_i;
                        m_q   <= bus.size_h_i;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i_q <= '0;
                    if (n_q == '0 || m_q == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_INIT_J;
                    end
                end
                S_INIT_J: begin
                    // Addresses are registered here so they are stable for the whole READ cycle.
                    j_q      <= j_start_c;
                    j_end_q  <= j_end_c;
                    acc_q    <= '0;
                    x_addr_q <= j_start_c;
                    h_addr_q <= DATA_WIDTH'(i_q - {1'b0, j_start_c});
                    state    <= S_READ;
                end
                S_READ: begin
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc_q <= acc_next;
                    if (j_q == j_end_q) begin
                        // Result registers are loaded here so they hold until the next WRITE.
                        y_we_q   <= 1'b1;
                        y_addr_q <= i_q;
                        y_data_q <= acc_next;
                        state    <= S_WRITE;
                    end else begin
                        j_q      <= j_q + DATA_WIDTH'(1);
                        x_addr_q <= j_q + DATA_WIDTH'(1);
                        h_addr_q <= h_addr_q - DATA_WIDTH'(1);
                        state    <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (i_q == i_last) begin
                        state <= S_DONE;
                    end else begin
                        i_q   <= i_q + IW'(1);
                        state <= S_INIT_J;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x_addr_o = x_addr_q;
    assign bus.h_addr_o = h_addr_q;
    assign bus.y_we_o   = y_we_q;
    assign bus.y_addr_o = y_addr_q;
    assign bus.y_data_o = y_data_q;
    assign bus.busy_o   = (state != S_IDLE);
    assign bus.done_o   = (state == S_DONE);

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Purpose : self-checking bench for conv_mac_sequencer with x/h memory models and a direct-sum reference.
// Latency : expected run length derived from the tap count of each output index.
// Backpressure: none; memories answer one cycle after the address.
module tb_conv_mac_sequencer;

    localparam int DW = 5;
    localparam int SW = 8;
    localparam int AW = 2*SW+DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   checks   = 0;
    int   failures = 0;

    logic [SW-1:0] x_mem [32];
    logic [SW-1:0] h_mem [32];
    longint        got_y [64];

    conv_mac_sequencer_if #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AW)) bus();

    conv_mac_sequencer #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read sample memories.
    always @(posedge clk) begin
        bus.x_data_i <= x_mem[bus.x_addr_o];
        bus.h_data_i <= h_mem[bus.h_addr_o];
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we"},    longint'(bus.y_we_o),   0);
        chk({tag, "_busy"},  longint'(bus.busy_o),   0);
        chk({tag, "_done"},  longint'(bus.done_o),   0);
        chk({tag, "_xaddr"}, longint'(bus.x_addr_o), 0);
        chk({tag, "_haddr"}, longint'(bus.h_addr_o), 0);
        chk({tag, "_yaddr"}, longint'(bus.y_addr_o), 0);
        chk({tag, "_ydata"}, longint'(bus.y_data_o), 0);
    endtask

    // One run: model computed from the convolution definition, then cycle-by-cycle observation.
    // restart_at > 0 pulses start_i again in that cycle; reset_after > 0 asserts rstn after that many writes.
    task automatic run(input int n, input int m, input int restart_at, input int reset_after);
        longint exp_y [64];
        int d, exp_writes, wcount, dcount, k, s0, taps;
        exp_writes = (n == 0 || m == 0) ? 0 : n + m - 1;
        if (exp_writes == 0) begin
            d = 2;
        end else begin
            d = 1;
            for (int i = 0; i < exp_writes; i++) begin
                exp_y[i] = 0;
                taps = 0;
                for (int j = 0; j < n; j++) begin
                    if (i - j >= 0 && i - j < m) begin
                        exp_y[i] += longint'(x_mem[j]) * longint'(h_mem[i-j]);
                        taps++;
                    end
                end
                d += 2 + 2*taps;
            end
            d += 1;
        end

        @(negedge clk);
        bus.size_x_i = DW'(n);
        bus.size_h_i = DW'(m);
        bus.start_i  = 1'b1;
        s0 = cyc;
        wcount = 0;
        dcount = 0;
        for (int t = 0; t <= d; t++) begin
            @(negedge clk);
            k = cyc - s0;
            bus.start_i = 1'b0;
            if (k == restart_at) begin
                bus.start_i  = 1'b1;
                bus.size_x_i = DW'(9);
                bus.size_h_i = DW'(9);
            end
            chk("busy", longint'(bus.busy_o), (k <= d) ? 1 : 0);
            if (bus.y_we_o === 1'b1) begin
                if (wcount < exp_writes) begin
                    chk("y_addr", longint'(bus.y_addr_o), wcount);
                    chk("y_data", longint'(bus.y_data_o), exp_y[wcount]);
                end
                got_y[bus.y_addr_o] = longint'(bus.y_data_o);
                wcount++;
            end
            if (bus.done_o === 1'b1) begin
                chk("done_cycle", k, d);
                dcount++;
            end
            if (reset_after > 0 && wcount == reset_after) begin
                rstn = 1'b0;
                #1;
                chk_quiet("rst_mid");
                @(negedge clk);
                chk_quiet("rst_hold");
                rstn = 1'b1;
                return;
            end
        end
        bus.start_i = 1'b0;
        chk("write_count", wcount, exp_writes);
        chk("done_count", dcount, 1);
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.size_x_i = '0;
        bus.size_h_i = '0;
        for (int a = 0; a < 32; a++) begin
            x_mem[a] = '0;
            h_mem[a] = '0;
        end
        for (int a = 0; a < 64; a++) got_y[a] = -1;

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rstn = 1'b1;

        // Small known case.
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        h_mem[0] = 8'd1; h_mem[1] = 8'd1;
        run(3, 2, -1, -1);
        chk("basic_y0", got_y[0], 1);
        chk("basic_y1", got_y[1], 3);
        chk("basic_y2", got_y[2], 5);
        chk("basic_y3", got_y[3], 3);

        // Single tap at full scale.
        x_mem[0] = 8'd255; h_mem[0] = 8'd255;
        run(1, 1, -1, -1);
        chk("single_y0", got_y[0], 65025);

        // Maximum lengths, all samples at full scale.
        for (int a = 0; a < 32; a++) begin
            x_mem[a] = 8'd255;
            h_mem[a] = 8'd255;
        end
        run(31, 31, -1, -1);
        chk("max_y0",  got_y[0],  65025);
        chk("max_y30", got_y[30], 2015775);
        chk("max_y60", got_y[60], 65025);

        // Empty x: immediate done, no writes.
        run(0, 5, -1, -1);
        run(4, 0, -1, -1);

        // Second start while busy must be ignored.
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        h_mem[0] = 8'd1; h_mem[1] = 8'd1;
        run(3, 2, 5, -1);

        // Reset after the second write, then a fresh run.
        for (int a = 0; a < 32; a++) begin
            x_mem[a] = SW'($urandom_range(0, 255));
            h_mem[a] = SW'($urandom_range(0, 255));
        end
        run(4, 3, -1, 2);
        run(4, 3, -1, -1);

        // Randomized lengths and data.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 32; a++) begin
                x_mem[a] = SW'($urandom_range(0, 255));
                h_mem[a] = SW'($urandom_range(0, 255));
            end
            run($urandom_range(1, 12), $urandom_range(1, 12), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
